// File: rtl/note_sequencer_pkg.sv
// Shared types and constants for the note sequencer: FSM state encoding,
// score word layout and default sizing.
package note_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LATCH = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } seq_state_e;

  localparam int SCORE_W    = 15;
  localparam int PERIOD_MSB = 14;
  localparam int PERIOD_LSB = 1;
  localparam int PERIOD_W   = PERIOD_MSB - PERIOD_LSB + 1;
  localparam int REST_BIT   = 0;

  localparam int DEF_LENGTH   = 783;
  localparam int DEF_TICK_DIV = 16_666_666;
  localparam int DEF_AW       = 10;

  // Counter width for a modulo-n count; a single bit is kept when n <= 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/note_sequencer_step_timer.sv
// Step timer: counts enabled cycles modulo TICK_DIV; tick_last flags the
// final count of a note step.
module step_timer
  import note_sequencer_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick_last
);

  localparam int TW = cnt_width(TICK_DIV);

  logic [TW-1:0] cnt_q, cnt_d;

  assign tick_last = (cnt_q == TW'(TICK_DIV - 1));

  // Wrap at the last count so the counter never exceeds TICK_DIV-1.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick_last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/note_sequencer.sv
// Score player: fetches {period, rest} words from a ROM and holds each note
// for TICK_DIV cycles. Define SEQ_LOOP_EN to replay the score endlessly.
//
//   state | meaning
//   IDLE  | waiting for start after reset
//   FETCH | rom_en high, rom_addr = idx
//   LATCH | rom_data captured into the note outputs, timer cleared
//   HOLD  | step timer running (frozen while paused)
//   DONE  | score finished, silent until start
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter int LENGTH   = DEF_LENGTH,
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int AW       = DEF_AW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                pause,
  output logic                rom_en,
  output logic [AW-1:0]       rom_addr,
  input  logic [SCORE_W-1:0]  rom_data,
  output logic [PERIOD_W-1:0] note_period,
  output logic                note_rest,
  output logic                note_valid,
  output logic                note_strobe,
  output logic                done
);

  seq_state_e          state_q, state_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                rest_q, rest_d;
  logic                valid_q, valid_d;
  logic                strobe_q, strobe_d;
  logic                tmr_clr, tmr_en, tick_last;

  step_timer #(.TICK_DIV(TICK_DIV)) u_step_timer (
    .clk       (clk),
    .rst       (rst),
    .clr       (tmr_clr),
    .en        (tmr_en),
    .tick_last (tick_last)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    period_d = period_q;
    rest_d   = rest_q;
    valid_d  = valid_q;
    strobe_d = 1'b0;
    tmr_clr  = 1'b0;
    tmr_en   = 1'b0;
    if (start) begin
      state_d = FETCH;
      idx_d   = '0;
    end else begin
      case (state_q)
        FETCH: state_d = LATCH;
        LATCH: begin
          period_d = rom_data[PERIOD_MSB:PERIOD_LSB];
          rest_d   = rom_data[REST_BIT];
          valid_d  = 1'b1;
          strobe_d = 1'b1;
          tmr_clr  = 1'b1;
          state_d  = HOLD;
        end
        HOLD: begin
          tmr_en = !pause;
          if (!pause && tick_last) begin
            if (idx_q < AW'(LENGTH - 1)) begin
              idx_d   = idx_q + 1'b1;
              state_d = FETCH;
            end else begin
`ifdef SEQ_LOOP_EN
              idx_d   = '0;
              state_d = FETCH;
`else
              valid_d = 1'b0;
              state_d = DONE;
`endif
            end
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      period_q <= '0;
      rest_q   <= 1'b0;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      period_q <= period_d;
      rest_q   <= rest_d;
      valid_q  <= valid_d;
      strobe_q <= strobe_d;
    end
  end

  assign rom_en      = (state_q == FETCH);
  assign rom_addr    = (state_q == FETCH) ? idx_q : '0;
  assign note_period = period_q;
  assign note_valid  = valid_q;
  assign note_strobe = strobe_q;
  assign done        = (state_q == DONE);
  // A silent note, a pause or no note at all all mute the buzzer.
  assign note_rest   = rest_q || pause || (period_q == '0) || !valid_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer with a small ROM model; expected
// timing is derived from note step arithmetic (TICK_DIV + 2 per note).
module tb_note_sequencer;

  localparam int LEN = 3;
  localparam int TD  = 4;
  localparam int AW  = 4;
  localparam int NF  = 64;

  logic        clk = 1'b0;
  logic        rst, start, pause;
  logic        rom_en;
  logic [AW-1:0] rom_addr;
  logic [14:0] rom_data = '0;
  logic [13:0] note_period;
  logic        note_rest, note_valid, note_strobe, done;

  int total = 0;
  int bad   = 0;

  logic [13:0] rom_per  [LEN];
  logic        rom_rest [LEN];

  note_sequencer #(.LENGTH(LEN), .TICK_DIV(TD), .AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pause       (pause),
    .rom_en      (rom_en),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .note_period (note_period),
    .note_rest   (note_rest),
    .note_valid  (note_valid),
    .note_strobe (note_strobe),
    .done        (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rom_en) begin
      if (int'(rom_addr) < LEN) rom_data <= {rom_per[int'(rom_addr)], rom_rest[int'(rom_addr)]};
      else                      rom_data <= '0;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; pause = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load_spec_rom();
    rom_per[0] = 14'd100; rom_rest[0] = 1'b0;
    rom_per[1] = 14'd0;   rom_rest[1] = 1'b0;
    rom_per[2] = 14'd200; rom_rest[2] = 1'b1;
  endtask

  task automatic load_random_rom();
    for (int i = 0; i < LEN; i++) begin
      rom_per[i]  = ($urandom_range(0, 2) == 0) ? 14'd0 : 14'($urandom_range(1, 16383));
      rom_rest[i] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic check_reset_values(input string tag);
    total += 7;
    if (rom_en !== 1'b0)       begin bad++; $display("FAIL %s rom_en got=%b want=0", tag, rom_en); end
    if (rom_addr !== '0)       begin bad++; $display("FAIL %s rom_addr got=%0d want=0", tag, rom_addr); end
    if (note_period !== 14'd0) begin bad++; $display("FAIL %s note_period got=%0d want=0", tag, note_period); end
    if (note_rest !== 1'b1)    begin bad++; $display("FAIL %s note_rest got=%b want=1", tag, note_rest); end
    if (note_valid !== 1'b0)   begin bad++; $display("FAIL %s note_valid got=%b want=0", tag, note_valid); end
    if (note_strobe !== 1'b0)  begin bad++; $display("FAIL %s note_strobe got=%b want=0", tag, note_strobe); end
    if (done !== 1'b0)         begin bad++; $display("FAIL %s done got=%b want=0", tag, done); end
  endtask

  // Pulses start, then checks ncyc cycles. Cycle t=0 is the first cycle after
  // start is sampled. Note k is fetched at ft[k] and visible from ft[k]+2; each
  // note occupies TD+2 cycles, and note 0 is stretched by a pause of plen
  // cycles that begins pstart cycles into its hold.
  task automatic run_check(input string tag, input int ncyc, input int pstart, input int plen);
    int ft[NF];
    int nf, done_t, pw0;
    logic e_en, e_stb, e_done, e_valid, e_rest, pz;
    int e_addr, cur, ci;
    ft[0] = 0;
    for (int k = 1; k < NF; k++) ft[k] = ft[k-1] + TD + 2 + ((k == 1) ? plen : 0);
`ifdef SEQ_LOOP_EN
    nf = NF; done_t = 1 << 30;
`else
    nf = LEN; done_t = ft[LEN-1] + 2 + TD + ((LEN == 1) ? plen : 0);
`endif
    pw0 = 2 + pstart;
    @(negedge clk);
    start = 1'b1; pause = 1'b0;
    for (int t = 0; t < ncyc; t++) begin
      @(negedge clk);
      start = 1'b0;
      pz = (t >= pw0) && (t < pw0 + plen);
      pause = pz;
      #1;
      e_en = 1'b0; e_stb = 1'b0; e_addr = 0; cur = -1;
      for (int k = 0; k < nf; k++) begin
        if (ft[k] == t) begin e_en = 1'b1; e_addr = k % LEN; end
        if (ft[k] + 2 == t) e_stb = 1'b1;
        if (ft[k] + 2 <= t) cur = k;
      end
      e_done  = (t >= done_t);
      e_valid = (cur >= 0) && !e_done;
      ci      = (cur >= 0) ? cur % LEN : 0;
      e_rest  = !e_valid || rom_rest[ci] || pz || (rom_per[ci] == 14'd0);
      total += 3;
      if (rom_en !== e_en) begin bad++; $display("FAIL %s rom_en t=%0d got=%b want=%b", tag, t, rom_en, e_en); end
      if (note_strobe !== e_stb) begin bad++; $display("FAIL %s note_strobe t=%0d got=%b want=%b", tag, t, note_strobe, e_stb); end
      if (done !== e_done) begin bad++; $display("FAIL %s done t=%0d got=%b want=%b", tag, t, done, e_done); end
      if (e_en) begin
        total++;
        if (int'(rom_addr) !== e_addr) begin bad++; $display("FAIL %s rom_addr t=%0d got=%0d want=%0d", tag, t, rom_addr, e_addr); end
      end
      if (t >= 2) begin
        total += 2;
        if (note_valid !== e_valid) begin bad++; $display("FAIL %s note_valid t=%0d got=%b want=%b", tag, t, note_valid, e_valid); end
        if (note_rest !== e_rest) begin bad++; $display("FAIL %s note_rest t=%0d got=%b want=%b", tag, t, note_rest, e_rest); end
        if (e_valid) begin
          total++;
          if (note_period !== rom_per[ci]) begin bad++; $display("FAIL %s note_period t=%0d got=%0d want=%0d", tag, t, note_period, rom_per[ci]); end
        end
      end
    end
    pause = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b1; pause = 1'b0;
    @(negedge clk);
    #1;
    check_reset_values("reset_with_start");
    rst = 1'b0; start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check_reset_values("idle_after_reset");
    end
  endtask

  task automatic test_spec_score();
    load_spec_rom();
    do_reset();
`ifdef SEQ_LOOP_EN
    run_check("spec_loop", 45, 0, 0);
`else
    run_check("spec_play", 26, 0, 0);
`endif
  endtask

  task automatic test_pause();
    load_spec_rom();
    do_reset();
    run_check("pause_fixed", 30, 1, 10);
    for (int r = 0; r < 3; r++) begin
      load_random_rom();
      do_reset();
      run_check("pause_rand", 34, $urandom_range(0, TD - 1), $urandom_range(1, 10));
    end
  endtask

  task automatic test_abort();
    load_spec_rom();
    do_reset();
    run_check("abort_pre", (TD + 2) + 2 + $urandom_range(0, TD - 1), 0, 0);
    run_check("abort_restart", 26, 0, 0);
  endtask

  task automatic test_reset_in_latch();
    load_spec_rom();
    do_reset();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_values("rst_in_latch");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check_reset_values("rst_in_latch_after");
    end
  endtask

  task automatic test_random_scores();
    for (int r = 0; r < 4; r++) begin
      load_random_rom();
      do_reset();
      run_check("random_score", 28, 0, 0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0;
    load_spec_rom();
    test_reset();
    test_spec_score();
    test_pause();
    test_abort();
    test_reset_in_latch();
    test_random_scores();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
